// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter/sequencer for a shared tri-state register bank.
// Optional preset strobe: define REG_ARB_PRESET_EN.
module reg_bank_arbiter #(
    parameter int NrOfReq  = 4,
    parameter int AddrBits = 2,
    parameter int NrOfBits = 8
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Tick,
    input  logic [NrOfReq-1:0]           req,
    input  logic [NrOfReq-1:0]           we,
    input  logic [NrOfReq*AddrBits-1:0]  addr,
    input  logic [NrOfReq*NrOfBits-1:0]  wdata,
    input  logic [NrOfBits-1:0]          bus_q,
`ifdef REG_ARB_PRESET_EN
    input  logic                         preset_req,
    output logic [(2**AddrBits)-1:0]     reg_pre,
`endif
    output logic [NrOfReq-1:0]           gnt,
    output logic [NrOfReq-1:0]           ack,
    output logic [NrOfBits-1:0]          rdata,
    output logic [NrOfBits-1:0]          bus_d,
    output logic [(2**AddrBits)-1:0]     reg_ce,
    output logic [(2**AddrBits)-1:0]     reg_cs
);

    localparam int NrOfRegs = 2**AddrBits;
    localparam int IdxBits  = $clog2(NrOfReq);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ACCESS,
        S_DONE,
        S_PRESET
    } state_t;

    state_t state, state_d;

    logic [IdxBits-1:0]  ptr, ptr_d;
    logic [IdxBits-1:0]  win, win_d;
    logic                win_we, win_we_d;
    logic [AddrBits-1:0] win_addr, win_addr_d;
    logic [NrOfBits-1:0] win_wdata, win_wdata_d;

    logic [NrOfReq-1:0]  gnt_d, ack_d;
    logic [NrOfBits-1:0] rdata_d, bus_d_d;
    logic [NrOfRegs-1:0] ce_d, cs_d;

    logic                pick_ok;
    logic [IdxBits-1:0]  pick_idx;
    logic [IdxBits-1:0]  cand;

    logic [NrOfRegs-1:0] addr_hot;
    logic [NrOfReq-1:0]  win_hot;
    logic [NrOfReq-1:0]  pick_hot;

`ifdef REG_ARB_PRESET_EN
    logic [NrOfRegs-1:0] pre_d;
`endif

    assign addr_hot = NrOfRegs'(1) << win_addr;
    assign win_hot  = NrOfReq'(1) << win;
    assign pick_hot = NrOfReq'(1) << pick_idx;

    // First requester after the last winner, wrapping modulo NrOfReq.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int off = 1; off <= NrOfReq; off++) begin
            cand = IdxBits'((int'(ptr) + off) % NrOfReq);
            if (!pick_ok && req[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        win_d       = win;
        win_we_d    = win_we;
        win_addr_d  = win_addr;
        win_wdata_d = win_wdata;
        gnt_d       = gnt;
        ack_d       = ack;
        rdata_d     = rdata;
        bus_d_d     = bus_d;
        ce_d        = reg_ce;
        cs_d        = reg_cs;
`ifdef REG_ARB_PRESET_EN
        pre_d       = reg_pre;
`endif
        if (Tick) begin
            unique case (state)
                S_IDLE: begin
`ifdef REG_ARB_PRESET_EN
                    if (preset_req) begin
                        pre_d   = '1;
                        state_d = S_PRESET;
                    end else
`endif
                    if (pick_ok) begin
                        win_d       = pick_idx;
                        win_we_d    = we[pick_idx];
                        win_addr_d  = addr[pick_idx*AddrBits +: AddrBits];
                        win_wdata_d = wdata[pick_idx*NrOfBits +: NrOfBits];
                        gnt_d       = pick_hot;
                        state_d     = S_ARB;
                    end
                end
                S_ARB: begin
                    if (win_we) begin
                        bus_d_d = win_wdata;
                        ce_d    = addr_hot;
                    end else begin
                        cs_d    = ~addr_hot;
                    end
                    state_d = S_ACCESS;
                end
                S_ACCESS: begin
                    ce_d  = '0;
                    cs_d  = '1;
                    if (!win_we)
                        rdata_d = bus_q;
                    ack_d   = win_hot;
                    ptr_d   = win;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    ack_d   = '0;
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
`ifdef REG_ARB_PRESET_EN
                S_PRESET: begin
                    pre_d   = '0;
                    state_d = S_IDLE;
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            ptr       <= IdxBits'(NrOfReq - 1);
            win       <= '0;
            win_we    <= 1'b0;
            win_addr  <= '0;
            win_wdata <= '0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            bus_d     <= '0;
            reg_ce    <= '0;
            reg_cs    <= '1;
`ifdef REG_ARB_PRESET_EN
            reg_pre   <= '0;
`endif
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            win       <= win_d;
            win_we    <= win_we_d;
            win_addr  <= win_addr_d;
            win_wdata <= win_wdata_d;
            gnt       <= gnt_d;
            ack       <= ack_d;
            rdata     <= rdata_d;
            bus_d     <= bus_d_d;
            reg_ce    <= ce_d;
            reg_cs    <= cs_d;
`ifdef REG_ARB_PRESET_EN
            reg_pre   <= pre_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a model register bank.
// Table vectors plus hand-written Tick-stall, reset-abort and preset cases.
module tb_reg_bank_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Tick;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  bus_q;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic [7:0]  bus_d;
    logic [3:0]  reg_ce;
    logic [3:0]  reg_cs;
`ifdef REG_ARB_PRESET_EN
    logic        preset_req;
    logic [3:0]  reg_pre;
`endif

    logic [7:0]  bank [4];

    int checks = 0;
    int errors = 0;
    int n;

    typedef struct {
        logic        rst;
        logic        tick;
        logic [3:0]  rq;
        logic [3:0]  w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [3:0]  eg;
        logic [3:0]  ea;
        logic [3:0]  ece;
        logic [3:0]  ecs;
        logic [7:0]  ebd;
        logic [7:0]  erd;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] h;
    logic [7:0] rv;
    logic [7:0] prv;

    reg_bank_arbiter dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Tick       (Tick),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .bus_q      (bus_q),
`ifdef REG_ARB_PRESET_EN
        .preset_req (preset_req),
        .reg_pre    (reg_pre),
`endif
        .gnt        (gnt),
        .ack        (ack),
        .rdata      (rdata),
        .bus_d      (bus_d),
        .reg_ce     (reg_ce),
        .reg_cs     (reg_cs)
    );

    always #5 Clock = ~Clock;

    // Model bank: write on ClockEnable, drive bus when cs low, pull-up otherwise.
    always @(posedge Clock) begin
        if (Reset) begin
            bank[0] <= 8'h11;
            bank[1] <= 8'h22;
            bank[2] <= 8'h33;
            bank[3] <= 8'h44;
        end else begin
            for (int i = 0; i < 4; i++)
                if (reg_ce[i])
                    bank[i] <= bus_d;
        end
    end

    always_comb begin
        bus_q = 8'hFF;
        for (int i = 0; i < 4; i++)
            if (!reg_cs[i])
                bus_q = bank[i];
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step(input string nm,
                        input logic r, input logic t,
                        input logic [3:0] rq, input logic [3:0] w,
                        input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] eg, input logic [3:0] ea,
                        input logic [3:0] ece, input logic [3:0] ecs,
                        input logic [7:0] ebd, input logic [7:0] erd);
        Reset = r;
        Tick  = t;
        req   = rq;
        we    = w;
        addr  = a;
        wdata = wd;
        @(posedge Clock);
        #1;
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        chk({nm, " ack"}, 32'(ack), 32'(ea));
        chk({nm, " reg_ce"}, 32'(reg_ce), 32'(ece));
        chk({nm, " reg_cs"}, 32'(reg_cs), 32'(ecs));
        chk({nm, " bus_d"}, 32'(bus_d), 32'(ebd));
        chk({nm, " rdata"}, 32'(rdata), 32'(erd));
        chk({nm, " invariant"},
            32'($onehot0(reg_ce) && $onehot0(~reg_cs) &&
                !((|reg_ce) && !(&reg_cs))), 32'd1);
    endtask

    function automatic vec_t mk(logic r, logic t, logic [3:0] rq,
                                logic [3:0] w, logic [7:0] a,
                                logic [31:0] wd, logic [3:0] eg,
                                logic [3:0] ea, logic [3:0] ece,
                                logic [3:0] ecs, logic [7:0] ebd,
                                logic [7:0] erd);
        vec_t v;
        v = '{r, t, rq, w, a, wd, eg, ea, ece, ecs, ebd, erd};
        return v;
    endfunction

    initial begin
`ifdef REG_ARB_PRESET_EN
        preset_req = 1'b0;
`endif
        // All four requesters reading their own index; order 0,1,2,3,0.
        prv = 8'h00;
        for (int t = 0; t < 5; t++) begin
            h  = 4'(1 << (t % 4));
            rv = 8'(8'h11 * ((t % 4) + 1));
            tbl.push_back(mk(0, 1, 4'hF, 4'h0, 8'hE4, 0, h, 0, 0, 4'hF, 0, prv));
            tbl.push_back(mk(0, 1, 4'hF, 4'h0, 8'hE4, 0, h, 0, 0, ~h, 0, prv));
            tbl.push_back(mk(0, 1, 4'hF, 4'h0, 8'hE4, 0, h, h, 0, 4'hF, 0, rv));
            tbl.push_back(mk(0, 1, 4'hF, 4'h0, 8'hE4, 0, 0, 0, 0, 4'hF, 0, rv));
            prv = rv;
        end
        // req0 writes A5 to reg2, dropping req after the grant.
        tbl.push_back(mk(0, 1, 4'h1, 4'h1, 8'h02, 32'hA5, 4'h1, 0, 0, 4'hF, 8'h00, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h1, 0, 4'h4, 4'hF, 8'hA5, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h1, 4'h1, 0, 4'hF, 8'hA5, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'hA5, 8'h11));
        // req3 writes 3C to reg2.
        tbl.push_back(mk(0, 1, 4'h8, 4'h8, 8'h80, 32'h3C000000, 4'h8, 0, 0, 4'hF, 8'hA5, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h8, 0, 4'h4, 4'hF, 8'h3C, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h8, 4'h8, 0, 4'hF, 8'h3C, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h3C, 8'h11));
        // req1 reads reg2 back.
        tbl.push_back(mk(0, 1, 4'h2, 4'h0, 8'h08, 0, 4'h2, 0, 0, 4'hF, 8'h3C, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h2, 0, 0, 4'hB, 8'h3C, 8'h11));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h2, 4'h2, 0, 4'hF, 8'h3C, 8'h3C));
        tbl.push_back(mk(0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h3C, 8'h3C));

        step("reset0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0);
        step("reset1", 1, 1, 4'hF, 4'hF, 8'hFF, 32'hFFFFFFFF,
             0, 0, 0, 4'hF, 0, 0);

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].tick,
                 tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].wd,
                 tbl[i].eg, tbl[i].ea, tbl[i].ece, tbl[i].ecs,
                 tbl[i].ebd, tbl[i].erd);

        // Tick low for three cycles while in ACCESS.
        step("stall_gnt", 0, 1, 4'h1, 4'h0, 8'h00, 0, 4'h1, 0, 0, 4'hF, 8'h3C, 8'h3C);
        step("stall_arb", 0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h1, 0, 0, 4'hE, 8'h3C, 8'h3C);
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_hold%0d", i), 0, 0, 4'h0, 4'h0, 8'h00, 0,
                 4'h1, 0, 0, 4'hE, 8'h3C, 8'h3C);
        Tick = 1'b1;
        n = 0;
        do begin
            @(posedge Clock);
            #1;
            n++;
        end while (ack == 4'h0 && n < 4);
        chk("stall ack_delay", 32'(n), 32'd1);
        chk("stall ack", 32'(ack), 32'h1);
        chk("stall rdata", 32'(rdata), 32'h11);
        chk("stall reg_cs", 32'(reg_cs), 32'hF);
        step("stall_done", 0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h3C, 8'h11);

        // Reset while the FSM is in ARB of a req2 write aborts it.
        step("abort_gnt", 0, 1, 4'h4, 4'h4, 8'h30, 32'h00770000,
             4'h4, 0, 0, 4'hF, 8'h3C, 8'h11);
        step("abort_rst", 1, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 0, 0);
        step("abort_idle", 0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 0, 0);
        step("abort_idle2", 0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 0, 0);
        step("retry_gnt", 0, 1, 4'h4, 4'h4, 8'h30, 32'h00770000,
             4'h4, 0, 0, 4'hF, 0, 0);
        step("retry_ce", 0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h4, 0, 4'h8, 4'hF, 8'h77, 0);
        step("retry_ack", 0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h4, 4'h4, 0, 4'hF, 8'h77, 0);
        step("retry_done", 0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h77, 0);
        chk("retry bank3", 32'(bank[3]), 32'h77);

`ifdef REG_ARB_PRESET_EN
        // Preset outranks req0; req0 is served right after.
        preset_req = 1'b1;
        step("pre_strobe", 0, 1, 4'h1, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h77, 0);
        chk("pre_strobe reg_pre", 32'(reg_pre), 32'hF);
        preset_req = 1'b0;
        step("pre_end", 0, 1, 4'h1, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h77, 0);
        chk("pre_end reg_pre", 32'(reg_pre), 32'h0);
        step("pre_gnt", 0, 1, 4'h1, 4'h0, 8'h00, 0, 4'h1, 0, 0, 4'hF, 8'h77, 0);
        step("pre_arb", 0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h1, 0, 0, 4'hE, 8'h77, 0);
        step("pre_ack", 0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h1, 4'h1, 0, 4'hF, 8'h77, 8'h11);
        step("pre_done", 0, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 4'hF, 8'h77, 8'h11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of tri-stated register flip-flops between several requesters over a single data bus.
- Drives each register's ClockEnable (write strobe) and cs (output disable; cs=1 → Q is high-Z).
- Runs one read or one write per granted transaction; returns ack and captured read data.
- Sits between the datapath front-ends (layer/pixel buffer engines) and the shared scratch register bank.

Parameters:
- NrOfReq, 4, number of requesters (2..8)
- AddrBits, 2, register select width; bank size NrOfRegs = 2**AddrBits
- NrOfBits, 8, data width of every register and of the bus

Ports:
- Clock  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- Tick  in  1  global clock-enable; FSM advances only when Tick=1
- req  in  NrOfReq  per-requester request level
- we  in  NrOfReq  per-requester op: 1=write, 0=read
- addr  in  NrOfReq*AddrBits  per-requester register index, requester i at [i*AddrBits +: AddrBits]
- wdata  in  NrOfReq*NrOfBits  per-requester write data, same packing
- bus_q  in  NrOfBits  shared tri-state bus from all register Q outputs
- gnt  out  NrOfReq  one-hot grant, held for the whole transaction
- ack  out  NrOfReq  one-cycle completion pulse to the winner
- rdata  out  NrOfBits  read data; valid in the ack cycle, held until the next read
- bus_d  out  NrOfBits  shared D input to all registers
- reg_ce  out  NrOfRegs  per-register ClockEnable
- reg_cs  out  NrOfRegs  per-register cs; 1 = high-Z

Behaviour:
- All outputs registered. Reset values: gnt=0, ack=0, rdata=0, bus_d=0, reg_ce=0, reg_cs=all 1s. RR pointer = NrOfReq-1, so requester 0 wins first. FSM=IDLE.
- FSM states IDLE→ARB→ACCESS→DONE→IDLE. Each transition requires Tick=1. With Tick=0, all state and outputs hold.
- IDLE: if any req=1, pick the first requester with req=1 searching from pointer+1 modulo NrOfReq. Latch its index, we, addr and wdata. Set gnt one-hot. Go to ARB. If no req, stay in IDLE.
- ARB, write: bus_d=latched wdata, reg_ce[addr]=1 (single bit). Go to ACCESS.
- ARB, read: reg_cs[addr]=0 (single bit). Go to ACCESS.
- ACCESS: deassert reg_ce (all 0) and reg_cs (all 1). On a read, rdata<=bus_q sampled on this edge. Set ack[winner]=1. Update pointer=winner. Go to DONE.
- DONE: ack=0, gnt=0. Go to IDLE.
- Latency with Tick held at 1: req seen at edge k → gnt visible after k, strobe after k+1, ack after k+2, IDLE after k+3. Throughput is one transaction per 4 cycles.
- Invariants:
  - at most one reg_ce bit high;
  - at most one reg_cs bit low;
  - reg_ce and a low reg_cs never occur in the same cycle.
- req dropping mid-transaction: the transaction still completes on its latched parameters.
- req still high in IDLE after ack: treated as a new request, arbitrated fairly against other requesters.
- Requester inputs are not sampled outside IDLE.
- Reset mid-transaction aborts it; no ack is issued and all outputs return to reset values on that edge.
- Reset has priority over Tick.

Optional Feature:
- Macro REG_ARB_PRESET_EN.
- When defined:
  - extra input preset_req (1) and extra output reg_pre (NrOfRegs).
  - In IDLE, preset_req=1 outranks all req. It drives reg_pre=all 1s for exactly one cycle (the ARB-equivalent state), then returns to IDLE.
  - No gnt and no ack are issued for a preset.
  - The RR pointer is unchanged.
- When undefined: neither port exists; behaviour is as above.

Test Plan:
- Reset, then req=4'b0001, we[0]=1, addr0=2, wdata0=8'hA5 → gnt=0001 after 1 cycle; reg_ce=4'b0100 with bus_d=A5 for exactly 1 cycle; ack[0] pulse 2 cycles after req.
- Model bank holds reg2=8'h3C. req[1] read of addr 2 → reg_cs=4'b1011 for 1 cycle; rdata=3C in the ack[1] cycle.
- req=4'b1111 held, all reads → grants in order 0,1,2,3,0 at 4-cycle spacing; exactly one ack per transaction.
- Tick low for 3 cycles during ACCESS → reg_cs/reg_ce/gnt frozen; ack delayed by exactly 3 cycles.
- Reset asserted in the ARB cycle of a write → reg_ce=0 next cycle; no ack; next req[2] is serviced from IDLE normally.
- REG_ARB_PRESET_EN: preset_req and req[0] raised together → reg_pre=all 1s for 1 cycle; then req[0] is granted.
